// File: rtl/fc_result_writer.sv
// Return-path writer: buffers FC output vectors in a small FIFO, packs each into
// one BRAM word and writes a batch to consecutive addresses from a host base.
module fc_result_writer #(
  parameter int DIM_OUTPUT  = 8,
  parameter int OUTPUT_W    = 8,
  parameter int BRAM_DAT_W  = 64,
  parameter int BRAM_ADDR_W = 14,
  parameter int BATCH_NUM   = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BRAM_ADDR_W-1:0]  base_addr,
  input  logic                    fc_out_vld,
  input  logic [OUTPUT_W-1:0]     fc_out_dat [DIM_OUTPUT],
  input  logic                    wr_gnt,
  output logic [BRAM_ADDR_W-1:0]  bram_addr,
  output logic [BRAM_DAT_W-1:0]   bram_din,
  output logic                    bram_en,
  output logic [BRAM_DAT_W/8-1:0] bram_we,
  output logic                    busy,
  output logic                    done,
  input  logic                    done_ack,
  output logic                    ovf
);

  localparam int CNT_W = $clog2(BATCH_NUM + 1);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int WE_W  = BRAM_DAT_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [BRAM_ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [BRAM_DAT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [BRAM_DAT_W-1:0]  mem_d [FIFO_DEPTH];

  logic [BRAM_ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [BRAM_DAT_W-1:0]  bram_din_q, bram_din_d;
  logic                   bram_en_q, bram_en_d;
  logic [WE_W-1:0]        bram_we_q, bram_we_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;

  logic [BRAM_DAT_W-1:0]  pack_w;
  logic                   fifo_empty, fifo_full;
  logic                   pop, push;

  always_comb begin
    pack_w = '0;
    for (int i = 0; i < DIM_OUTPUT; i++) begin
      pack_w[i*OUTPUT_W +: OUTPUT_W] = fc_out_dat[i];
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop  = (state_q == S_RUN) && !fifo_empty && wr_gnt &&
                (wr_cnt_q < CNT_W'(BATCH_NUM));
  assign push = (state_q == S_RUN) && fc_out_vld &&
                (acc_cnt_q < CNT_W'(BATCH_NUM)) && (!fifo_full || pop);

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = pack_w;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    acc_cnt_d   = acc_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    bram_en_d   = 1'b0;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          base_d    = base_addr;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          ovf_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (push) begin
          wr_ptr_d  = wr_ptr_q + PTR_W'(1);
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end else if (fc_out_vld) begin
          ovf_d = 1'b1;
        end
        if (pop) begin
          rd_ptr_d    = rd_ptr_q + PTR_W'(1);
          wr_cnt_d    = wr_cnt_q + CNT_W'(1);
          bram_en_d   = 1'b1;
          bram_din_d  = mem_q[rd_ptr_q[IDX_W-1:0]];
          bram_addr_d = base_q +
                        BRAM_ADDR_W'(wr_cnt_q) * BRAM_ADDR_W'(WE_W);
        end
        // wr_cnt reaching BATCH_NUM means the final write is on the port now.
        if (wr_cnt_q == CNT_W'(BATCH_NUM)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (fc_out_vld) begin
          ovf_d = 1'b1;
        end
        if (done_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    bram_we_d = {WE_W{bram_en_d}};
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      acc_cnt_q   <= acc_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fc_result_writer.sv
// Bench for fc_result_writer: directed scenarios plus random batches, checked
// every cycle against a queue-based transaction model of the writer.
module tb_fc_result_writer;

  localparam int DEPTH = 4;
  localparam int BATCH = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] base_addr;
  logic        fc_out_vld;
  logic [7:0]  fc_out_dat [8];
  logic        wr_gnt;
  logic [13:0] bram_addr;
  logic [63:0] bram_din;
  logic        bram_en;
  logic [7:0]  bram_we;
  logic        busy;
  logic        done;
  logic        done_ack;
  logic        ovf;

  fc_result_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .fc_out_vld (fc_out_vld),
    .fc_out_dat (fc_out_dat),
    .wr_gnt     (wr_gnt),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .busy       (busy),
    .done       (done),
    .done_ack   (done_ack),
    .ovf        (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // transaction model state
  bit          m_run, m_done;
  logic [13:0] m_base;
  int          m_acc, m_wr;
  logic [63:0] m_fifo [$];
  logic        e_en, e_busy, e_done, e_ovf;
  logic [13:0] e_addr;
  logic [63:0] e_din;

  // observed writes
  logic [13:0] cap_addr [$];
  logic [63:0] cap_din  [$];
  int          cap_edge [$];
  int          vld_edge [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pack_vec();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = fc_out_dat[i];
    return w;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_acc = 0; m_wr = 0; m_base = '0;
    m_fifo.delete();
    e_en = 0; e_busy = 0; e_done = 0; e_ovf = 0; e_addr = '0; e_din = '0;
  endtask

  // Predicts the registered outputs after the coming edge from the current inputs.
  task automatic model_step();
    bit finish;
    e_en = 0;
    if (!m_run && !m_done) begin
      if (start) begin
        m_run = 1; m_base = base_addr; m_acc = 0; m_wr = 0; e_ovf = 0;
        m_fifo.delete();
      end
    end else if (m_run) begin
      finish = (m_wr == BATCH);
      if (m_fifo.size() > 0 && wr_gnt && m_wr < BATCH) begin
        e_din  = m_fifo.pop_front();
        e_en   = 1;
        e_addr = 14'((int'(m_base) + m_wr * 8) % 16384);
        m_wr++;
      end
      if (fc_out_vld) begin
        if (m_acc < BATCH && m_fifo.size() < DEPTH) begin
          m_fifo.push_back(pack_vec());
          m_acc++;
        end else begin
          e_ovf = 1;
        end
      end
      if (finish) begin
        m_run = 0; m_done = 1;
      end
    end else begin
      if (fc_out_vld) e_ovf = 1;
      if (done_ack) m_done = 0;
    end
    e_busy = m_run || m_done;
    e_done = m_done;
  endtask

  task automatic check_all();
    chk("bram_en",   bram_en,   e_en);
    chk("bram_we",   bram_we,   e_en ? 8'hFF : 8'h00);
    chk("bram_addr", bram_addr, e_addr);
    chk("bram_din",  bram_din,  e_din);
    chk("busy",      busy,      e_busy);
    chk("done",      done,      e_done);
    chk("ovf",       ovf,       e_ovf);
  endtask

  // driver: one clock with the currently driven inputs, then check and clear pulses
  task automatic step();
    model_step();
    @(posedge clk);
    cyc++;
    #1;
    check_all();
    if (bram_en === 1'b1) begin
      cap_addr.push_back(bram_addr);
      cap_din.push_back(bram_din);
      cap_edge.push_back(cyc);
    end
    start = 0; fc_out_vld = 0; done_ack = 0;
  endtask

  task automatic clear_cap();
    cap_addr.delete(); cap_din.delete(); cap_edge.delete(); vld_edge.delete();
  endtask

  task automatic rand_vec();
    for (int i = 0; i < 8; i++) fc_out_dat[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic start_batch(input logic [13:0] base);
    base_addr = base;
    start = 1;
    step();
  endtask

  task automatic run_batch();
    for (int c = 0; c < 400 && !m_done; c++) begin
      wr_gnt = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        rand_vec();
        fc_out_vld = 1;
      end
      if ($urandom_range(0, 15) == 0) begin
        base_addr = 14'($urandom_range(0, 16383));
        start = 1;
      end
      if ($urandom_range(0, 15) == 0) done_ack = 1;
      step();
    end
    chk("batch_done", done, 1'b1);
  endtask

  task automatic ack_batch();
    done_ack = 1;
    step();
    step();
    chk("ack_busy", busy, 1'b0);
    chk("ack_done", done, 1'b0);
  endtask

  initial begin
    rst_n = 0; start = 0; base_addr = '0; fc_out_vld = 0; wr_gnt = 0; done_ack = 0;
    for (int i = 0; i < 8; i++) fc_out_dat[i] = '0;
    model_reset();
    #2;
    check_all();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // basic batch: spaced vectors with known content
    wr_gnt = 1;
    clear_cap();
    start_batch(14'h0100);
    for (int k = 0; k < BATCH; k++) begin
      for (int i = 0; i < 8; i++) fc_out_dat[i] = 8'(k * 16 + i);
      fc_out_vld = 1;
      step();
      vld_edge.push_back(cyc);
      for (int j = 0; j < 4; j++) step();
    end
    chk("basic_count", 64'(cap_addr.size()), 64'd10);
    for (int k = 0; k < cap_addr.size() && k < BATCH; k++) begin
      chk("basic_addr", cap_addr[k], 14'(14'h0100 + k * 8));
      chk("basic_latency", 64'(cap_edge[k] - vld_edge[k]), 64'd1);
    end
    if (cap_din.size() > 0) chk("basic_word0", cap_din[0], 64'h0706050403020100);
    chk("basic_done", done, 1'b1);
    start = 1;
    step();
    chk("start_in_done", done, 1'b1);
    ack_batch();
    done_ack = 1;
    step();

    // grant stall: FIFO fills, fifth vector dropped
    clear_cap();
    wr_gnt = 0;
    start_batch(14'($urandom_range(0, 16383)));
    for (int k = 0; k < 5; k++) begin
      rand_vec();
      fc_out_vld = 1;
      step();
    end
    chk("stall_ovf", ovf, 1'b1);
    wr_gnt = 1;
    for (int k = 0; k < 6; k++) step();
    chk("stall_writes", 64'(cap_addr.size()), 64'd4);
    chk("stall_done", done, 1'b0);
    run_batch();
    ack_batch();

    // full FIFO with a pop and a push in the same cycle
    wr_gnt = 0;
    start_batch(14'h0200);
    chk("restart_ovf_clear", ovf, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rand_vec();
      fc_out_vld = 1;
      step();
    end
    wr_gnt = 1;
    rand_vec();
    fc_out_vld = 1;
    step();
    chk("full_pop_ovf", ovf, 1'b0);
    run_batch();
    ack_batch();

    // address wrap, excess vector, illegal start/done_ack in RUN
    clear_cap();
    wr_gnt = 1;
    start_batch(14'h3FF8);
    for (int k = 0; k < BATCH; k++) begin
      rand_vec();
      fc_out_vld = 1;
      step();
    end
    rand_vec();
    fc_out_vld = 1;
    start = 1;
    base_addr = 14'h1234;
    done_ack = 1;
    step();
    chk("excess_ovf", ovf, 1'b1);
    for (int c = 0; c < 20 && !m_done; c++) step();
    chk("wrap_count", 64'(cap_addr.size()), 64'd10);
    if (cap_addr.size() >= 10) begin
      chk("wrap_second", cap_addr[1], 14'h0000);
      chk("wrap_last",   cap_addr[9], 14'h0040);
    end
    chk("wrap_done", done, 1'b1);
    ack_batch();

    // reset in the middle of a batch
    clear_cap();
    wr_gnt = 1;
    start_batch(14'h0500);
    for (int k = 0; k < 3; k++) begin
      rand_vec();
      fc_out_vld = 1;
      step();
    end
    step();
    wr_gnt = 0;
    for (int k = 0; k < 2; k++) begin
      rand_vec();
      fc_out_vld = 1;
      step();
    end
    chk("pre_reset_writes", 64'(cap_addr.size()), 64'd3);
    #3;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1;
    clear_cap();
    wr_gnt = 1;
    for (int k = 0; k < 6; k++) begin
      rand_vec();
      fc_out_vld = (k % 2 == 0);
      step();
    end
    chk("post_reset_no_write", 64'(cap_addr.size()), 64'd0);
    start_batch(14'h0A00);
    rand_vec();
    fc_out_vld = 1;
    step();
    step();
    chk("post_reset_count", 64'(cap_addr.size()), 64'd1);
    if (cap_addr.size() > 0) chk("post_reset_base", cap_addr[0], 14'h0A00);
    run_batch();
    ack_batch();

    // random batches
    for (int b = 0; b < 4; b++) begin
      start_batch(14'($urandom_range(0, 16383)));
      run_batch();
      ack_batch();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fc_result_writer.md
Name: fc_result_writer

Overview:
Return-path writer for the FC inference datapath. It captures each output vector from the FC layer (DIM_OUTPUT neurons × OUTPUT_W bits), buffers it in a small FIFO and packs it into one BRAM_DAT_W word. It writes the batch into the shared result BRAM through a native BRAM port, starting at a host-supplied base address. Once BATCH_NUM words are committed it raises a done flag, which the host clears with an acknowledge.

Parameters:
DIM_OUTPUT, 8, neurons per output vector
OUTPUT_W, 8, bits per neuron output
BRAM_DAT_W, 64, BRAM data width; must equal DIM_OUTPUT*OUTPUT_W
BRAM_ADDR_W, 14, BRAM byte-address width
BATCH_NUM, 10, vectors (words) per batch
FIFO_DEPTH, 4, vector buffer depth (power of 2, ≥2)

Ports:
clk  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms a batch (honoured only in IDLE)
base_addr  in  BRAM_ADDR_W  byte address of first result word; sampled on accepted start
fc_out_vld  in  1  one-cycle strobe; fc_out_dat valid
fc_out_dat  in  OUTPUT_W × DIM_OUTPUT (unpacked array)  neuron outputs, index 0..DIM_OUTPUT-1
wr_gnt  in  1  BRAM port grant; writer may drive bram_en only when 1
bram_addr  out  BRAM_ADDR_W  byte address
bram_din  out  BRAM_DAT_W  packed write data
bram_en  out  1  port enable
bram_we  out  BRAM_DAT_W/8  byte write enables (all ones or all zeros)
busy  out  1  high in RUN and DONE
done  out  1  batch committed; held until done_ack
done_ack  in  1  one-cycle pulse; clears done (honoured only in DONE)
ovf  out  1  sticky: vector dropped; cleared on next accepted start

Behaviour:
- Reset: all outputs 0, FIFO empty, counters 0, state IDLE. Takes effect immediately. Reset mid-batch discards all buffered and partial state; no BRAM write may follow reset deassertion until a new start.
- All outputs are registered.
- States:
  - IDLE: on start, latch base_addr, clear acc_cnt, wr_cnt and ovf, go to RUN. fc_out_vld is ignored in IDLE.
  - RUN, accept side: on fc_out_vld with acc_cnt<BATCH_NUM and FIFO not full, push the vector and increment acc_cnt.
    - vld with FIFO full: vector dropped, ovf set to 1, acc_cnt unchanged.
    - vld with acc_cnt==BATCH_NUM (excess vector): dropped, ovf set to 1.
    - Push and pop in the same cycle with FIFO full: push is accepted, because occupancy is evaluated after the pop.
  - RUN, write side: each cycle the FIFO is non-empty and wr_gnt=1, pop one entry. Next cycle: bram_en=1, bram_we=all ones, bram_din=packed entry, bram_addr=base+wr_cnt*(BRAM_DAT_W/8) modulo 2^BRAM_ADDR_W; wr_cnt increments.
    - Cycles with no pop: bram_en=0, bram_we=0; bram_addr and bram_din hold their last values.
    - The pop decision uses wr_gnt in the same cycle; a grant drop stalls the next pop, never a write already issued.
  - RUN→DONE: on the cycle the BATCH_NUM-th write is issued. In the next cycle done=1 and bram_en=0.
  - DONE: done=1 and busy=1 until done_ack, then IDLE with done=0 next cycle. fc_out_vld in DONE sets ovf.
- start outside IDLE and done_ack outside DONE are ignored.
- Packing: neuron i occupies bram_din[i*OUTPUT_W +: OUTPUT_W], least significant neuron at index 0, no sign manipulation.
- Latency: with wr_gnt held at 1, bram_en rises in the second cycle after the fc_out_vld cycle (2 clock edges). Back-to-back vld gives back-to-back writes.
- Counter widths: acc_cnt and wr_cnt are clog2(BATCH_NUM+1) bits. FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.

Test Plan:
- Basic batch:
  - Stimulus: reset; start with base_addr=0x0100; wr_gnt=1; 10 vld pulses spaced 5 cycles, vector k holds neuron i = k*16+i.
  - Required: 10 writes at addresses 0x0100,0x0108,…,0x0148; word 0 = 0x0706050403020100; each bram_en exactly 2 cycles after its vld; done=1 after write 10; done_ack→IDLE, busy=0.
- Grant stall / FIFO full:
  - Stimulus: wr_gnt=0; 5 consecutive vld pulses.
  - Required: first 4 buffered, 5th dropped, ovf=1. After wr_gnt=1: 4 writes in consecutive cycles, in order; done stays 0 (acc_cnt=4).
- Full with simultaneous pop:
  - Stimulus: FIFO holds 4 entries; wr_gnt rises and vld arrives in the same cycle.
  - Required: vld accepted, ovf stays 0.
- Address wrap:
  - Stimulus: base_addr=0x3FF8, BATCH_NUM=10.
  - Required: second write at address 0x0000.
- Excess and illegal controls:
  - Stimulus: 11th vld after 10 accepted; start pulse in RUN; done_ack in RUN.
  - Required: 11th dropped with ovf=1; base address and counters unchanged; state unaffected.
- Reset mid-operation:
  - Stimulus: assert rst_n low after 3 writes with 2 entries queued.
  - Required: all outputs 0 immediately; no bram_en after release until a new start; new batch begins at the newly sampled base_addr.
